// File: rtl/arith_scheduler_if.sv
// Command and response handshake bundle between a requester and the arith_scheduler.
interface arith_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_op;
  logic [15:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_data
  );
endinterface

// File: rtl/arith_scheduler.sv
// Command scheduler for the multiplier and cube-root units sharing one 16-bit adder.
//
// state  | meaning
// IDLE   | waiting for a queued command and a free response slot
// ISSUE  | start pulse to the selected unit
// ARM    | guard cycle while the unit's registered busy settles
// WAIT   | unit running; capture result when busy drops
module arith_scheduler #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic               clk,
  input  logic               rst,
  arith_scheduler_if.slave   bus,
  output logic [7:0]         mul_a_o,
  output logic [7:0]         mul_b_o,
  output logic               mul_start_o,
  input  logic               mul_busy_i,
  input  logic [15:0]        mul_result_i,
  input  logic [15:0]        mul_add_a_i,
  input  logic [15:0]        mul_add_b_i,
  output logic [7:0]         cbrt_x_o,
  output logic               cbrt_start_o,
  input  logic               cbrt_busy_i,
  input  logic [2:0]         cbrt_result_i,
  input  logic [15:0]        cbrt_add_a_i,
  input  logic [15:0]        cbrt_add_b_i,
  output logic [15:0]        add_a_o,
  output logic [15:0]        add_b_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [16:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            job_op_q;
  logic [7:0]      job_a_q, job_b_q;
  logic            rsp_valid_q, rsp_op_q;
  logic [15:0]     rsp_data_q;
  logic            push, pop, capture, empty, full, sel_busy;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign push     = bus.cmd_valid && !full;
  assign sel_busy = job_op_q ? cbrt_busy_i : mul_busy_i;

  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_data  = rsp_data_q;
  assign mul_a_o       = job_a_q;
  assign mul_b_o       = job_b_q;
  assign cbrt_x_o      = job_a_q;

  // FIFO storage; validity is tracked by the pointers, so contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, start pulses and adder routing
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    capture      = 1'b0;
    mul_start_o  = 1'b0;
    cbrt_start_o = 1'b0;
    add_a_o      = '0;
    add_b_o      = '0;
    case (state_q)
      S_IDLE: begin
        if (!empty && (!rsp_valid_q || bus.rsp_ready)) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start_o  = !job_op_q;
        cbrt_start_o = job_op_q;
        state_d      = S_ARM;
      end
      S_ARM:  state_d = S_WAIT;
      S_WAIT: begin
        if (!sel_busy) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE) begin
      add_a_o = job_op_q ? cbrt_add_a_i : mul_add_a_i;
      add_b_o = job_op_q ? cbrt_add_b_i : mul_add_b_i;
    end
  end

  // Job registers, loaded only when a command is popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_op_q <= 1'b0;
      job_a_q  <= '0;
      job_b_q  <= '0;
    end else if (pop) begin
      {job_op_q, job_a_q, job_b_q} <= mem_q[rd_ptr_q];
    end
  end

  // Response slot; a fresh capture takes priority over a retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else if (capture) begin
      rsp_valid_q <= 1'b1;
      rsp_op_q    <= job_op_q;
      rsp_data_q  <= job_op_q ? {13'd0, cbrt_result_i} : mul_result_i;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

endmodule
